// File: rtl/e_m_pipe_reg_if.sv
// E->M pipeline register bus: E-stage fields in, registered M-stage fields and
// M-stage forwarding information out.
interface e_m_pipe_reg_if;
  logic        en;
  logic        clr;
  logic [31:0] E_PC;
  logic [31:0] E_instr;
  logic [31:0] E_ALUout;
  logic [31:0] E_rt_data;
  logic [4:0]  E_A3;
  logic [1:0]  E_WDsel;
  logic [1:0]  E_Tnew;
  logic [31:0] M_PC;
  logic [31:0] M_instr;
  logic [31:0] M_ALUout;
  logic [31:0] M_rt_data;
  logic [4:0]  M_A3;
  logic [1:0]  M_WDsel;
  logic [1:0]  M_Tnew;
  logic        M_valid;
  logic [31:0] M_fwd_data;
  logic [4:0]  M_fwd_A3;

  modport master (
    output en, clr, E_PC, E_instr, E_ALUout, E_rt_data, E_A3, E_WDsel, E_Tnew,
    input  M_PC, M_instr, M_ALUout, M_rt_data, M_A3, M_WDsel, M_Tnew, M_valid,
           M_fwd_data, M_fwd_A3
  );

  modport slave (
    input  en, clr, E_PC, E_instr, E_ALUout, E_rt_data, E_A3, E_WDsel, E_Tnew,
    output M_PC, M_instr, M_ALUout, M_rt_data, M_A3, M_WDsel, M_Tnew, M_valid,
           M_fwd_data, M_fwd_A3
  );
endinterface

// File: rtl/e_m_pipe_reg.sv
// E->M pipeline register of the 5-stage MIPS core with hold, bubble insertion,
// Tnew decrement and the M-stage forwarding outputs.
module e_m_pipe_reg #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [1:0]  WD_ALU   = 2'd0,
  parameter logic [1:0]  WD_MEM   = 2'd1,
  parameter logic [1:0]  WD_PC8   = 2'd2
) (
  input  logic           clk,
  input  logic           reset,
  e_m_pipe_reg_if.slave  bus
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_alu;
  logic [31:0] r_rt;
  logic [4:0]  r_a3;
  logic [1:0]  r_wdsel;
  logic [1:0]  r_tnew;
  logic        r_valid;

  logic [31:0] w_fwd_data;
  logic [4:0]  w_fwd_a3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= PC_RESET;
      r_instr <= '0;
      r_alu   <= '0;
      r_rt    <= '0;
      r_a3    <= '0;
      r_wdsel <= '0;
      r_tnew  <= '0;
      r_valid <= 1'b0;
    end else if (bus.clr) begin
      // Bubble: identical to the reset image, so it never writes or forwards.
      r_pc    <= PC_RESET;
      r_instr <= '0;
      r_alu   <= '0;
      r_rt    <= '0;
      r_a3    <= '0;
      r_wdsel <= '0;
      r_tnew  <= '0;
      r_valid <= 1'b0;
    end else if (bus.en) begin
      r_pc    <= bus.E_PC;
      r_instr <= bus.E_instr;
      r_alu   <= bus.E_ALUout;
      r_rt    <= bus.E_rt_data;
      r_a3    <= bus.E_A3;
      r_wdsel <= bus.E_WDsel;
      r_tnew  <= (bus.E_Tnew == 2'd0) ? 2'd0 : bus.E_Tnew - 2'd1;
      r_valid <= 1'b1;
    end
  end

  always_comb begin
    w_fwd_data = r_alu;
    unique case (r_wdsel)
      WD_PC8:         w_fwd_data = r_pc + 32'd8;
      WD_ALU, WD_MEM: w_fwd_data = r_alu;
      default:        w_fwd_data = r_alu;
    endcase
  end

  // Loads are not ready until W; GPR 0 falls out naturally as "no forward".
  assign w_fwd_a3 = (r_valid && (r_tnew == 2'd0) && (r_wdsel != WD_MEM)) ? r_a3 : 5'd0;

  assign bus.M_PC       = r_pc;
  assign bus.M_instr    = r_instr;
  assign bus.M_ALUout   = r_alu;
  assign bus.M_rt_data  = r_rt;
  assign bus.M_A3       = r_a3;
  assign bus.M_WDsel    = r_wdsel;
  assign bus.M_Tnew     = r_tnew;
  assign bus.M_valid    = r_valid;
  assign bus.M_fwd_data = w_fwd_data;
  assign bus.M_fwd_A3   = w_fwd_a3;

endmodule

// File: tb/tb_e_m_pipe_reg.sv
// Self-checking bench for e_m_pipe_reg: directed scenarios plus randomized traffic
// checked against a field-level model of the M-stage contents.
module tb_e_m_pipe_reg;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  e_m_pipe_reg_if bus ();

  e_m_pipe_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  a3;
    logic [1:0]  wdsel;
    logic [1:0]  tnew;
    logic        valid;
  } mstate_t;

  mstate_t exp_st;

  function automatic mstate_t bubble();
    mstate_t s;
    s = '0;
    s.pc = 32'h0000_3000;
    return s;
  endfunction

  // Next M contents from the current E inputs: bubble on clr, load on en, else hold.
  function automatic mstate_t model_next(mstate_t cur);
    mstate_t s;
    int t;
    s = cur;
    if (bus.clr) begin
      s = bubble();
    end else if (bus.en) begin
      t = int'(bus.E_Tnew) - 1;
      if (t < 0) t = 0;
      s.pc    = bus.E_PC;
      s.instr = bus.E_instr;
      s.alu   = bus.E_ALUout;
      s.rt    = bus.E_rt_data;
      s.a3    = bus.E_A3;
      s.wdsel = bus.E_WDsel;
      s.tnew  = 2'(t);
      s.valid = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [36:0] model_fwd(mstate_t s);
    logic [31:0] d;
    logic [4:0]  a;
    d = (s.wdsel == 2'd2) ? s.pc + 32'd8 : s.alu;
    a = (s.valid && s.tnew == 2'd0 && s.wdsel != 2'd1) ? s.a3 : 5'd0;
    return {d, a};
  endfunction

  function automatic mstate_t dut_state();
    return {bus.M_PC, bus.M_instr, bus.M_ALUout, bus.M_rt_data, bus.M_A3, bus.M_WDsel,
            bus.M_Tnew, bus.M_valid};
  endfunction

  task automatic tick();
    exp_st = model_next(exp_st);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] a3,
                       input logic [1:0] wdsel, input logic [1:0] tnew);
    bus.E_PC      = pc;
    bus.E_instr   = instr;
    bus.E_ALUout  = alu;
    bus.E_rt_data = rt;
    bus.E_A3      = a3;
    bus.E_WDsel   = wdsel;
    bus.E_Tnew    = tnew;
  endtask

  task automatic test_reset();
    bus.en = 1'b1;
    bus.clr = 1'b0;
    drive(32'h0000_3abc, 32'h0123_4567, 32'hdead_beef, 32'h5, 5'd7, 2'd0, 2'd0);
    @(posedge clk);
    #1;
    checks++;
    if (bus.M_PC !== 32'h3000 || bus.M_valid !== 1'b0 || bus.M_A3 !== 5'd0) begin
      errors++;
      $display("FAIL reset_held: pc=%h valid=%b a3=%0d, required pc=00003000 valid=0 a3=0",
               bus.M_PC, bus.M_valid, bus.M_A3);
    end
    #3 reset = 1'b1;
    exp_st = bubble();
    tick();
    checks++;
    if (bus.M_valid !== 1'b1 || bus.M_PC !== 32'h3abc) begin
      errors++;
      $display("FAIL reset_release_load: valid=%b pc=%h, required valid=1 pc=00003abc",
               bus.M_valid, bus.M_PC);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.M_PC !== 32'h3000 || bus.M_valid !== 1'b0 || bus.M_fwd_A3 !== 5'd0 ||
        bus.M_ALUout !== 32'h0 || bus.M_instr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: pc=%h valid=%b fwd_a3=%0d alu=%h instr=%h, required 3000/0/0/0/0",
               bus.M_PC, bus.M_valid, bus.M_fwd_A3, bus.M_ALUout, bus.M_instr);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_st = bubble();
  endtask

  task automatic test_alu();
    drive(32'h3004, 32'h0109_4021, 32'h1234_5678, 32'h11, 5'd8, 2'd0, 2'd1);
    bus.en = 1'b1;
    bus.clr = 1'b0;
    tick();
    checks++;
    if (bus.M_ALUout !== 32'h1234_5678 || bus.M_Tnew !== 2'd0 || bus.M_fwd_A3 !== 5'd8 ||
        bus.M_fwd_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alu_pass: alu=%h tnew=%0d fwd_a3=%0d fwd=%h, required 12345678/0/8/12345678",
               bus.M_ALUout, bus.M_Tnew, bus.M_fwd_A3, bus.M_fwd_data);
    end
  endtask

  task automatic test_load();
    drive(32'h3008, 32'h8d09_0004, 32'h0000_0040, 32'h0, 5'd9, 2'd1, 2'd2);
    tick();
    checks++;
    if (bus.M_Tnew !== 2'd1 || bus.M_fwd_A3 !== 5'd0 || bus.M_A3 !== 5'd9) begin
      errors++;
      $display("FAIL load: tnew=%0d fwd_a3=%0d a3=%0d, required 1/0/9",
               bus.M_Tnew, bus.M_fwd_A3, bus.M_A3);
    end
    drive(32'h300c, 32'h8d09_0004, 32'h0000_0040, 32'h0, 5'd9, 2'd1, 2'd1);
    tick();
    checks++;
    if (bus.M_Tnew !== 2'd0 || bus.M_fwd_A3 !== 5'd0) begin
      errors++;
      $display("FAIL load_tnew0: tnew=%0d fwd_a3=%0d, required 0/0", bus.M_Tnew, bus.M_fwd_A3);
    end
  endtask

  task automatic test_link();
    drive(32'h3010, 32'h0c00_0c10, 32'h0, 32'h0, 5'd31, 2'd2, 2'd0);
    tick();
    checks++;
    if (bus.M_Tnew !== 2'd0 || bus.M_fwd_data !== 32'h3018 || bus.M_fwd_A3 !== 5'd31) begin
      errors++;
      $display("FAIL link: tnew=%0d fwd=%h fwd_a3=%0d, required 0/00003018/31",
               bus.M_Tnew, bus.M_fwd_data, bus.M_fwd_A3);
    end
  endtask

  task automatic test_hold_clear();
    drive(32'h3004, 32'h0109_4021, 32'h1234_5678, 32'h11, 5'd8, 2'd0, 2'd1);
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, $urandom, $urandom, 5'($urandom), 2'($urandom), 2'($urandom));
      tick();
      checks++;
      if (bus.M_ALUout !== 32'h1234_5678 || bus.M_A3 !== 5'd8 || bus.M_valid !== 1'b1 ||
          bus.M_PC !== 32'h3004 || bus.M_Tnew !== 2'd0 || bus.M_rt_data !== 32'h11) begin
        errors++;
        $display("FAIL hold_%0d: alu=%h a3=%0d valid=%b pc=%h tnew=%0d rt=%h, required held values",
                 i, bus.M_ALUout, bus.M_A3, bus.M_valid, bus.M_PC, bus.M_Tnew, bus.M_rt_data);
      end
    end
    bus.en = 1'b1;
    bus.clr = 1'b1;
    tick();
    checks++;
    if (bus.M_valid !== 1'b0 || bus.M_A3 !== 5'd0 || bus.M_instr !== 32'h0 ||
        bus.M_PC !== 32'h3000 || bus.M_fwd_A3 !== 5'd0) begin
      errors++;
      $display("FAIL clear: valid=%b a3=%0d instr=%h pc=%h fwd_a3=%0d, required 0/0/0/3000/0",
               bus.M_valid, bus.M_A3, bus.M_instr, bus.M_PC, bus.M_fwd_A3);
    end
    bus.clr = 1'b0;
  endtask

  task automatic test_edges();
    bus.en = 1'b1;
    drive(32'hffff_fffc, 32'h0, 32'h0, 32'h0, 5'd4, 2'd2, 2'd3);
    tick();
    checks++;
    if (bus.M_Tnew !== 2'd2 || bus.M_fwd_data !== 32'h0000_0004 || bus.M_fwd_A3 !== 5'd0) begin
      errors++;
      $display("FAIL edge_tnew3_pcwrap: tnew=%0d fwd=%h fwd_a3=%0d, required 2/00000004/0",
               bus.M_Tnew, bus.M_fwd_data, bus.M_fwd_A3);
    end
    drive(32'h3020, 32'h0000_0021, 32'h55, 32'h0, 5'd0, 2'd0, 2'd0);
    tick();
    checks++;
    if (bus.M_fwd_A3 !== 5'd0 || bus.M_valid !== 1'b1) begin
      errors++;
      $display("FAIL edge_a3_zero: fwd_a3=%0d valid=%b, required 0/1", bus.M_fwd_A3, bus.M_valid);
    end
    drive(32'h3024, 32'h0, 32'hcafe_f00d, 32'h0, 5'd12, 2'd3, 2'd0);
    tick();
    checks++;
    if (bus.M_fwd_data !== 32'hcafe_f00d || bus.M_fwd_A3 !== 5'd12) begin
      errors++;
      $display("FAIL edge_wdsel3: fwd=%h fwd_a3=%0d, required cafef00d/12",
               bus.M_fwd_data, bus.M_fwd_A3);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.en  = ($urandom_range(0, 3) != 0);
      bus.clr = ($urandom_range(0, 9) == 0);
      drive($urandom, $urandom, $urandom, $urandom, 5'($urandom), 2'($urandom), 2'($urandom));
      tick();
      checks++;
      if (dut_state() !== exp_st) begin
        errors++;
        $display("FAIL random_state_%0d: got %h, required %h", i, dut_state(), exp_st);
      end
      checks++;
      if ({bus.M_fwd_data, bus.M_fwd_A3} !== model_fwd(exp_st)) begin
        errors++;
        $display("FAIL random_fwd_%0d: got %h/%0d, required %h", i, bus.M_fwd_data,
                 bus.M_fwd_A3, model_fwd(exp_st));
      end
    end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.clr = 1'b0;
    drive('0, '0, '0, '0, '0, '0, '0);
    exp_st = bubble();
    #2;
    test_reset();
    test_alu();
    test_load();
    test_link();
    test_hold_clear();
    test_edges();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
